// File: rtl/candidate_column_loader.sv
`default_nettype none
// ============================================================================
// Module : candidate_column_loader
// Assembles a serial pixel stream into 9-lane columns for the candidate buffer.
// Rev    : 1.0
// ============================================================================
module candidate_column_loader #(
  parameter int DATAWIDTH = 8,
  parameter int COLS      = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [DATAWIDTH-1:0] pix_in,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic [DATAWIDTH-1:0] out_0,
  output logic [DATAWIDTH-1:0] out_1,
  output logic [DATAWIDTH-1:0] out_2,
  output logic [DATAWIDTH-1:0] out_3,
  output logic [DATAWIDTH-1:0] out_4,
  output logic [DATAWIDTH-1:0] out_5,
  output logic [DATAWIDTH-1:0] out_6,
  output logic [DATAWIDTH-1:0] out_7,
  output logic [DATAWIDTH-1:0] out_8,
  output logic                 col_valid,
  input  logic                 col_ready,
  output logic                 col_last,
  output logic                 block_done
);

  localparam logic [0:0] c_st_fill  = 1'b0;
  localparam logic [0:0] c_st_hold  = 1'b1;
  localparam logic [3:0] c_last_row = 4'd8;
  localparam logic [7:0] c_last_col = 8'(COLS - 1);

  logic [0:0]           r_state;
  logic [0:0]           w_state_next;
  logic [3:0]           r_row_cnt;
  logic [7:0]           r_col_cnt;
  logic                 r_block_done;
  logic [DATAWIDTH-1:0] r_lane [9];
  logic                 w_pix_xfer;
  logic                 w_col_xfer;

  // clear wins over both handshakes, so it masks the transfer strobes
  assign w_pix_xfer = pix_valid && (r_state == c_st_fill) && !clear;
  assign w_col_xfer = col_ready && (r_state == c_st_hold) && !clear;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_fill;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = c_st_fill;
    end else begin
      case (r_state)
        c_st_fill: if (w_pix_xfer && (r_row_cnt == c_last_row)) w_state_next = c_st_hold;
        c_st_hold: if (w_col_xfer) w_state_next = c_st_fill;
        default:   w_state_next = c_st_fill;
      endcase
    end
  end

  always_comb begin
    pix_ready = (r_state == c_st_fill);
    col_valid = (r_state == c_st_hold);
    col_last  = (r_state == c_st_hold) && (r_col_cnt == c_last_col);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_row_cnt    <= 4'd0;
      r_col_cnt    <= 8'd0;
      r_block_done <= 1'b0;
    end else if (clear) begin
      r_row_cnt    <= 4'd0;
      r_col_cnt    <= 8'd0;
      r_block_done <= 1'b0;
    end else begin
      r_block_done <= 1'b0;
      if (w_pix_xfer) begin
        r_row_cnt <= (r_row_cnt == c_last_row) ? 4'd0 : r_row_cnt + 4'd1;
      end
      if (w_col_xfer) begin
        if (r_col_cnt == c_last_col) begin
          r_col_cnt    <= 8'd0;
          r_block_done <= 1'b1;
        end else begin
          r_col_cnt <= r_col_cnt + 8'd1;
        end
      end
    end
  end

  // Lanes are written in place by row index; unwritten lanes keep old data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 9; k++) r_lane[k] <= '0;
    end else if (w_pix_xfer) begin
      for (int k = 0; k < 9; k++) begin
        if (r_row_cnt == 4'(k)) r_lane[k] <= pix_in;
      end
    end
  end

  assign out_0      = r_lane[0];
  assign out_1      = r_lane[1];
  assign out_2      = r_lane[2];
  assign out_3      = r_lane[3];
  assign out_4      = r_lane[4];
  assign out_5      = r_lane[5];
  assign out_6      = r_lane[6];
  assign out_7      = r_lane[7];
  assign out_8      = r_lane[8];
  assign block_done = r_block_done;

endmodule
`default_nettype wire
